// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: FSM states, opcodes,
// ALU operation codes and datapath mux selects.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_MUL = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // funct3 codes this core has no ALU operation for (xor, shifts right, sltu).
    function automatic logic is_reserved_funct3(input logic [2:0] f3);
        return (f3 == 3'b011) || (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALUOp/funct decode to the 3-bit ALUControl code.
// Defining MUL_EN makes R-type funct3=000 with funct7b0=1 decode to multiply.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       op5_i,
    input  logic       funct7b5_i,
    input  logic       funct7b0_i,
    output logic [2:0] alu_control_o
);

`ifndef MUL_EN
    logic unused_funct7b0;
    assign unused_funct7b0 = funct7b0_i;
`endif

    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    3'b000: begin
                        // op5 separates register forms from immediates, whose bit 30 is data
                        if (op5_i && funct7b5_i) begin
                            alu_control_o = ALU_SUB;
                        end
`ifdef MUL_EN
                        else if (op5_i && funct7b0_i) begin
                            alu_control_o = ALU_MUL;
                        end
`endif
                    end
                    3'b001:  alu_control_o = ALU_SLL;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RISC-V core; drives all datapath enables and selects.
// Optional multiply support is compiled in with MUL_EN.
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       funct7b0,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal
);

    state_t     state_q, state_d;
    logic       pc_update;
    logic       branch;
    logic [1:0] alu_op;
    logic       instr_illegal;
    logic       mul_ok;
    logic       is_rtype;
    logic       is_itype;
    logic       known_op;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign is_rtype = (op == OP_RTYPE);
    assign is_itype = (op == OP_ITYPE);
    assign known_op = (op == OP_LW) || (op == OP_SW) || is_rtype || is_itype ||
                      (op == OP_BEQ) || (op == OP_JAL);

`ifdef MUL_EN
    assign mul_ok = (funct3 == 3'b000);
`else
    assign mul_ok = 1'b0;
`endif

    assign instr_illegal = !known_op ||
                           ((is_rtype || is_itype) && is_reserved_funct3(funct3)) ||
                           (is_rtype && funct7b0 && !mul_ok);

    always_comb begin
        state_d   = state_q;
        pc_update = 1'b0;
        branch    = 1'b0;
        alu_op    = ALUOP_ADD;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        illegal   = 1'b0;
        if (!reset_n) begin
            // Selects park on their FETCH values; every enable stays low.
            state_d   = S_FETCH;
            ResultSrc = RES_ALURESULT;
            ALUSrcB   = SRCB_FOUR;
        end else begin
            case (state_q)
                S_FETCH: begin
                    IRWrite   = 1'b1;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALURESULT;
                    pc_update = 1'b1;
                    state_d   = S_DECODE;
                end
                S_DECODE: begin
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_IMM;
                    if (instr_illegal) begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end else if (op == OP_LW || op == OP_SW) begin
                        state_d = S_MEMADR;
                    end else if (is_rtype) begin
                        state_d = S_EXECUTER;
                    end else if (is_itype) begin
                        state_d = S_EXECUTEI;
                    end else if (op == OP_BEQ) begin
                        state_d = S_BEQ;
                    end else begin
                        state_d = S_JAL;
                    end
                end
                S_MEMADR: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                    state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
                end
                S_MEMREAD: begin
                    AdrSrc  = 1'b1;
                    state_d = S_MEMWB;
                end
                S_MEMWB: begin
                    ResultSrc = RES_DATA;
                    RegWrite  = 1'b1;
                    state_d   = S_FETCH;
                end
                S_MEMWRITE: begin
                    AdrSrc   = 1'b1;
                    MemWrite = 1'b1;
                    state_d  = S_FETCH;
                end
                S_EXECUTER: begin
                    ALUSrcA = SRCA_RS1;
                    alu_op  = ALUOP_FUNCT;
                    state_d = S_ALUWB;
                end
                S_EXECUTEI: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                    alu_op  = ALUOP_FUNCT;
                    state_d = S_ALUWB;
                end
                S_ALUWB: begin
                    RegWrite = 1'b1;
                    state_d  = S_FETCH;
                end
                S_BEQ: begin
                    ALUSrcA = SRCA_RS1;
                    alu_op  = ALUOP_SUB;
                    branch  = 1'b1;
                    state_d = S_FETCH;
                end
                S_JAL: begin
                    ALUSrcA   = SRCA_OLDPC;
                    ALUSrcB   = SRCB_FOUR;
                    pc_update = 1'b1;
                    state_d   = S_ALUWB;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    assign PCWrite = pc_update | (branch & zero);

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = IMM_S;
            OP_BEQ:  ImmSrc = IMM_B;
            OP_JAL:  ImmSrc = IMM_J;
            default: ImmSrc = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op_i      (alu_op),
        .funct3_i      (funct3),
        .op5_i         (op[5]),
        .funct7b5_i    (funct7b5),
        .funct7b0_i    (funct7b0),
        .alu_control_o (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected output vectors are
// queued when an instruction is applied and compared on the following falling edges.
module tb_multicycle_controller;

    logic       clk;
    logic       reset_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       funct7b0;
    logic       zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    int vectors_applied = 0;
    int miscompares     = 0;
    logic [16:0] exp_q[$];

`ifdef MUL_EN
    localparam bit MUL = 1'b1;
`else
    localparam bit MUL = 1'b0;
`endif

    // Bench-side state numbering; sequences are packed one nibble per cycle, first at LSB.
    localparam int M_FETCH = 0, M_DECODE = 1, M_MEMADR = 2, M_MEMREAD = 3, M_MEMWB = 4;
    localparam int M_MEMWRITE = 5, M_EXECR = 6, M_EXECI = 7, M_ALUWB = 8, M_BEQ = 9, M_JAL = 10;

    multicycle_controller dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .funct7b0   (funct7b0),
        .zero       (zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .illegal    (illegal)
    );

    logic [16:0] dut_vec;
    assign dut_vec = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                      ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_vec(input string tag, input logic [16:0] got, input logic [16:0] exp);
        vectors_applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] model_alu(input logic [1:0] aop, input logic [2:0] f3,
                                             input logic op5, input logic f7b5, input logic f7b0);
        if (aop == 2'b00) return 3'b000;
        if (aop == 2'b01) return 3'b001;
        case (f3)
            3'b000:  return (op5 && f7b5) ? 3'b001 : ((MUL && op5 && f7b0) ? 3'b100 : 3'b000);
            3'b001:  return 3'b101;
            3'b010:  return 3'b110;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic model_illegal(input logic [6:0] o, input logic [2:0] f3, input logic f7b0);
        logic known, rt, it;
        rt = (o == 7'b0110011);
        it = (o == 7'b0010011);
        known = (o == 7'b0000011) || (o == 7'b0100011) || rt || it ||
                (o == 7'b1100011) || (o == 7'b1101111);
        return !known || ((rt || it) && (f3 == 3'd3 || f3 == 3'd4 || f3 == 3'd5)) ||
               (rt && f7b0 && !(MUL && f3 == 3'd0));
    endfunction

    function automatic logic [16:0] model_out(input int st, input logic rst_n, input logic [6:0] o,
                                              input logic [2:0] f3, input logic f7b5,
                                              input logic f7b0, input logic z);
        logic pcu = 0, brn = 0, adr = 0, mw = 0, irw = 0, rw = 0, ill = 0;
        logic [1:0] rs = 2'b00, sa = 2'b00, sb = 2'b00, aop = 2'b00, imm;
        case (o)
            7'b0100011: imm = 2'b01;
            7'b1100011: imm = 2'b10;
            7'b1101111: imm = 2'b11;
            default:    imm = 2'b00;
        endcase
        if (!rst_n) begin
            rs = 2'b10; sb = 2'b10;
        end else begin
            case (st)
                M_FETCH:    begin irw = 1; sb = 2'b10; rs = 2'b10; pcu = 1; end
                M_DECODE:   begin sa = 2'b01; sb = 2'b01; ill = model_illegal(o, f3, f7b0); end
                M_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
                M_MEMREAD:  begin adr = 1; end
                M_MEMWB:    begin rs = 2'b01; rw = 1; end
                M_MEMWRITE: begin adr = 1; mw = 1; end
                M_EXECR:    begin sa = 2'b10; aop = 2'b10; end
                M_EXECI:    begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
                M_ALUWB:    begin rw = 1; end
                M_BEQ:      begin sa = 2'b10; aop = 2'b01; brn = 1; end
                M_JAL:      begin sa = 2'b01; sb = 2'b10; pcu = 1; end
                default:    ;
            endcase
        end
        return {pcu | (brn & z), adr, mw, irw, rw, rs, sa, sb, imm,
                model_alu(aop, f3, o[5], f7b5, f7b0), ill};
    endfunction

    // Applies one instruction from FETCH; reset_n drops at cycle rst_at (negative = never).
    task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7b5, input logic f7b0, input logic z,
                             input logic [23:0] seq, input int n, input int rst_at);
        op = o; funct3 = f3; funct7b5 = f7b5; funct7b0 = f7b0; zero = z;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(model_out(int'(seq[4*i +: 4]), !(rst_at >= 0 && i >= rst_at),
                                      o, f3, f7b5, f7b0, z));
        end
        for (int i = 0; i < n; i++) begin
            if (i == rst_at) reset_n = 1'b0;
            @(negedge clk);
            check_vec($sformatf("%s.c%0d", tag, i), dut_vec, exp_q.pop_front());
            @(posedge clk);
            #1;
        end
        if (rst_at >= 0) reset_n = 1'b1;
        $display("instr %-10s op=%07b f3=%03b f7b5=%0b f7b0=%0b zero=%0b cycles=%0d",
                 tag, o, f3, f7b5, f7b0, z, n);
    endtask

    initial begin
        reset_n = 1'b0; op = 7'b0000011; funct3 = 3'b010;
        funct7b5 = 1'b0; funct7b0 = 1'b0; zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_vec($sformatf("reset.c%0d", i), dut_vec,
                      model_out(M_FETCH, 1'b0, op, funct3, funct7b5, funct7b0, zero));
            @(posedge clk);
        end
        #1;
        reset_n = 1'b1;

        run_instr("lw",       7'b0000011, 3'b010, 0, 0, 0, 24'h43210, 5, -1);
        run_instr("sw",       7'b0100011, 3'b010, 0, 0, 1, 24'h05210, 4, -1);
        run_instr("sub",      7'b0110011, 3'b000, 1, 0, 0, 24'h08610, 4, -1);
        run_instr("add",      7'b0110011, 3'b000, 0, 0, 1, 24'h08610, 4, -1);
        run_instr("and",      7'b0110011, 3'b111, 0, 0, 0, 24'h08610, 4, -1);
        run_instr("or",       7'b0110011, 3'b110, 0, 0, 0, 24'h08610, 4, -1);
        run_instr("sll",      7'b0110011, 3'b001, 0, 0, 0, 24'h08610, 4, -1);
        run_instr("addi_b30", 7'b0010011, 3'b000, 1, 0, 0, 24'h08710, 4, -1);
        run_instr("slti",     7'b0010011, 3'b010, 0, 1, 0, 24'h08710, 4, -1);
        run_instr("beq_t",    7'b1100011, 3'b000, 0, 0, 1, 24'h00910, 3, -1);
        run_instr("beq_nt",   7'b1100011, 3'b000, 0, 0, 0, 24'h00910, 3, -1);
        run_instr("jal",      7'b1101111, 3'b000, 0, 0, 0, 24'h08A10, 4, -1);
`ifdef MUL_EN
        run_instr("mul",      7'b0110011, 3'b000, 0, 1, 0, 24'h08610, 4, -1);
`else
        run_instr("mul_ill",  7'b0110011, 3'b000, 0, 1, 0, 24'h00010, 2, -1);
`endif
        run_instr("r_f7b0",   7'b0110011, 3'b111, 0, 1, 0, 24'h00010, 2, -1);
        run_instr("xor_ill",  7'b0110011, 3'b100, 0, 0, 0, 24'h00010, 2, -1);
        run_instr("srli_ill", 7'b0010011, 3'b101, 0, 0, 0, 24'h00010, 2, -1);
        run_instr("lui_ill",  7'b0110111, 3'b000, 0, 0, 0, 24'h00010, 2, -1);
        run_instr("sw_rst",   7'b0100011, 3'b010, 0, 0, 0, 24'h00210, 3, 2);
        run_instr("lw_after", 7'b0000011, 3'b010, 0, 0, 0, 24'h43210, 5, -1);

        @(negedge clk);
        check_vec("final_fetch", dut_vec,
                  model_out(M_FETCH, 1'b1, op, funct3, funct7b5, funct7b0, zero));

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
